// File: rtl/restoring_div_core_if.sv
// rtl/restoring_div_core_if.sv - request/result bundle between the CSR block and the divider
interface restoring_div_core_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            busy_o;
  logic            done_o;
  logic            fini_o;
  logic [XLEN-1:0] quotient_o;
  logic [XLEN-1:0] remainder_o;
  logic            div_by_zero_o;

  modport master (
    output start_i, dividend_i, divisor_i,
    input  busy_o, done_o, fini_o, quotient_o, remainder_o, div_by_zero_o
  );

  modport slave (
    input  start_i, dividend_i, divisor_i,
    output busy_o, done_o, fini_o, quotient_o, remainder_o, div_by_zero_o
  );
endinterface

// File: rtl/restoring_div_core.sv
// rtl/restoring_div_core.sv - unsigned radix-2 restoring divider, one quotient bit per clock
module restoring_div_core #(
  parameter int XLEN = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  restoring_div_core_if.slave  div_if
);
  localparam int CNTW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_rem;
  logic [CNTW-1:0] r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_fini;
  logic            r_dbz;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_remo;

  logic [XLEN:0]   w_trial;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_q_next;
  logic            w_accept;

  // Partial remainder stays below the divisor, so the trial difference's top
  // bit is a clean borrow flag: clear means the trial value covered the divisor.
  assign w_trial    = {r_rem, r_q[XLEN-1]};
  assign w_diff     = w_trial - {1'b0, r_div};
  assign w_ge       = ~w_diff[XLEN];
  assign w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
  assign w_q_next   = {r_q[XLEN-2:0], w_ge};
  assign w_accept   = div_if.start_i && (r_state != S_CALC);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fini  <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (div_if.divisor_i != '0) begin
          r_div   <= div_if.divisor_i;
          r_q     <= div_if.dividend_i;
          r_rem   <= '0;
          r_cnt   <= CNTW'(XLEN);
          r_fini  <= 1'b0;
          r_dbz   <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= S_CALC;
        end else begin
          // Divide by zero completes immediately with the conventional all-ones quotient.
          r_quot  <= '1;
          r_remo  <= div_if.dividend_i;
          r_dbz   <= 1'b1;
          r_done  <= 1'b1;
          r_fini  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
      end else if (r_state == S_CALC) begin
        r_rem <= w_rem_next;
        r_q   <= w_q_next;
        r_cnt <= r_cnt - CNTW'(1);
        if (r_cnt == CNTW'(1)) begin
          r_quot  <= w_q_next;
          r_remo  <= w_rem_next;
          r_done  <= 1'b1;
          r_fini  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
      end
    end
  end

  assign div_if.busy_o        = r_busy;
  assign div_if.done_o        = r_done;
  assign div_if.fini_o        = r_fini;
  assign div_if.quotient_o    = r_quot;
  assign div_if.remainder_o   = r_remo;
  assign div_if.div_by_zero_o = r_dbz;
endmodule

// File: tb/tb_restoring_div_core.sv
// tb/tb_restoring_div_core.sv - self-checking bench for restoring_div_core
module tb_restoring_div_core;
  localparam int XLEN = 32;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  restoring_div_core_if #(.XLEN(XLEN)) dif ();

  restoring_div_core #(.XLEN(XLEN)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .div_if  (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    dif.start_i    = 1'b1;
    dif.dividend_i = a;
    dif.divisor_i  = b;
    tick();
    dif.start_i    = 1'b0;
  endtask

  // Counts edges until done_o, and notes whether results moved while computing.
  task automatic wait_done(output int lat, output logic held);
    logic [31:0] q0;
    logic [31:0] r0;
    q0   = dif.quotient_o;
    r0   = dif.remainder_o;
    lat  = 0;
    held = 1'b1;
    while (!dif.done_o && lat < 40) begin
      if (dif.quotient_o !== q0 || dif.remainder_o !== r0 || !dif.busy_o) held = 1'b0;
      tick();
      lat++;
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er);
    int   lat;
    logic held;
    start_op(a, b);
    if (b == 0) begin
      chk({name, " dz_done"}, 32'(dif.done_o), 32'd1);
      chk({name, " dz_busy"}, 32'(dif.busy_o), 32'd0);
      chk({name, " dz_flag"}, 32'(dif.div_by_zero_o), 32'd1);
    end else begin
      chk({name, " busy_e0"}, 32'(dif.busy_o), 32'd1);
      chk({name, " fini_clr"}, 32'(dif.fini_o), 32'd0);
      wait_done(lat, held);
      chk({name, " latency"}, 32'(lat), 32'd32);
      chk({name, " held"}, 32'(held), 32'd1);
      chk({name, " dz_flag"}, 32'(dif.div_by_zero_o), 32'd0);
      chk({name, " busy_end"}, 32'(dif.busy_o), 32'd0);
    end
    chk({name, " q"}, dif.quotient_o, eq);
    chk({name, " r"}, dif.remainder_o, er);
    chk({name, " fini"}, 32'(dif.fini_o), 32'd1);
    tick();
    chk({name, " done_pulse"}, 32'(dif.done_o), 32'd0);
    chk({name, " fini_hold"}, 32'(dif.fini_o), 32'd1);
    chk({name, " q_hold"}, dif.quotient_o, eq);
  endtask

  initial begin
    vec_t        vecs[9];
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    int          lat;
    logic        held;
    logic        saw_done;

    total = 0;
    bad   = 0;
    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[3] = '{32'd3,          32'd10,         32'd0,          32'd3};
    vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0};
    vecs[5] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[6] = '{32'd50,         32'd6,          32'd8,          32'd2};
    vecs[7] = '{32'd1,          32'd1,          32'd1,          32'd0};
    vecs[8] = '{32'h8000_0000,  32'd3,          32'd715827882,  32'd2};

    dif.start_i    = 1'b0;
    dif.dividend_i = '0;
    dif.divisor_i  = '0;
    reset          = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst busy", 32'(dif.busy_o), 32'd0);
    chk("rst done", 32'(dif.done_o), 32'd0);
    chk("rst fini", 32'(dif.fini_o), 32'd0);
    chk("rst dz",   32'(dif.div_by_zero_o), 32'd0);
    chk("rst q",    dif.quotient_o, 32'd0);
    chk("rst r",    dif.remainder_o, 32'd0);

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

    // Start while computing is dropped; a start during the done cycle is taken.
    start_op(32'd100, 32'd7);
    for (int i = 0; i < 4; i++) tick();
    dif.start_i    = 1'b1;
    dif.dividend_i = 32'd9;
    dif.divisor_i  = 32'd2;
    tick();
    dif.start_i = 1'b0;
    chk("ign busy", 32'(dif.busy_o), 32'd1);
    wait_done(lat, held);
    chk("ign latency", 32'(lat + 5), 32'd32);
    chk("ign q", dif.quotient_o, 32'd14);
    chk("ign r", dif.remainder_o, 32'd2);
    start_op(32'd9, 32'd2);
    chk("b2b done", 32'(dif.done_o), 32'd0);
    chk("b2b fini", 32'(dif.fini_o), 32'd0);
    chk("b2b busy", 32'(dif.busy_o), 32'd1);
    wait_done(lat, held);
    chk("b2b latency", 32'(lat), 32'd32);
    chk("b2b q", dif.quotient_o, 32'd4);
    chk("b2b r", dif.remainder_o, 32'd1);
    tick();

    // Reset in the middle of a computation.
    start_op(32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid rst busy", 32'(dif.busy_o), 32'd0);
    chk("mid rst done", 32'(dif.done_o), 32'd0);
    chk("mid rst fini", 32'(dif.fini_o), 32'd0);
    chk("mid rst q",    dif.quotient_o, 32'd0);
    chk("mid rst r",    dif.remainder_o, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (dif.done_o || dif.busy_o) saw_done = 1'b1;
      tick();
    end
    chk("mid rst quiet", 32'(saw_done), 32'd0);
    run_op("post rst", 32'd50, 32'd6, 32'd8, 32'd2);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom & 32'h0000_00FF;
        2:       b = $urandom & 32'h000F_FFFF;
        default: b = (n % 8 == 3) ? 32'd0 : 32'(1) << $urandom_range(0, 31);
      endcase
      ref_div(a, b, eq, er);
      run_op($sformatf("rnd%0d", n), a, b, eq, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
